// File: rtl/adder_flit_if.sv
// Flit stream interface between the adder stimulus generator and its consumer.
// The master drives the operands and framing; the slave supplies start/out_ready.
interface adder_flit_if #(
  parameter int unsigned N = 21
) ();
  logic         start;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic [15:0]  flit_cnt;
  logic [15:0]  pkt_cnt;
  logic         busy;
  logic         done;

  modport master (
    input  start,
    input  out_ready,
    output out_valid,
    output input1,
    output input2,
    output flit_cnt,
    output pkt_cnt,
    output busy,
    output done
  );

  modport slave (
    output start,
    output out_ready,
    input  out_valid,
    input  input1,
    input  input2,
    input  flit_cnt,
    input  pkt_cnt,
    input  busy,
    input  done
  );
endinterface

// File: rtl/adder_flit_stim_gen.sv
// Packetized walking-mask operand generator for adder energy characterization.
// Define ADDER_STIM_LFSR_EN to source flit words from a 2N-bit Fibonacci LFSR instead.
module adder_flit_stim_gen #(
  parameter int unsigned N        = 21,
  parameter int unsigned PAYLOAD  = 20,
  parameter int unsigned GAP      = 7,
  parameter int unsigned NUM_PKTS = 10,
  parameter int unsigned STEPS    = 7,
  parameter int unsigned SH       = 6
) (
  input logic        clk,
  input logic        rst,
  adder_flit_if.master bus
);

  localparam int unsigned W          = 2 * N;
  localparam logic [W-1:0] Ones      = {W{1'b1}};
  localparam logic [15:0]  FlitLast  = 16'(PAYLOAD - 1);
  localparam logic [15:0]  PktLast   = 16'(NUM_PKTS - 1);
  localparam logic [15:0]  GapLast   = 16'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] flit_q, flit_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] gap_q, gap_d;
  logic [W-1:0] word_q;

  // seq_start loads the first word of a run; seq_adv presents the next word.
  logic         seq_start;
  logic         seq_adv;
  logic [W-1:0] first_word;
  logic [W-1:0] next_word;

  logic xfer;
  logic last_flit;
  logic last_pkt;

  assign xfer      = (state_q == StSend) && bus.out_ready;
  assign last_flit = (flit_q == FlitLast);
  assign last_pkt  = (pkt_q == PktLast);

  always_comb begin
    state_d   = state_q;
    flit_d    = flit_q;
    pkt_d     = pkt_q;
    gap_d     = gap_q;
    seq_start = 1'b0;
    seq_adv   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StSend;
          flit_d    = '0;
          pkt_d     = '0;
          gap_d     = '0;
          seq_start = 1'b1;
        end
      end
      StSend: begin
        if (xfer) begin
          if (!last_flit) begin
            flit_d  = flit_q + 16'd1;
            seq_adv = 1'b1;
          end else begin
            flit_d = '0;
            pkt_d  = pkt_q + 16'd1;
            if (last_pkt) begin
              state_d = StDone;
            end else if (GAP == 0) begin
              seq_adv = 1'b1;
            end else begin
              state_d = StGap;
              gap_d   = '0;
            end
          end
        end
      end
      StGap: begin
        // Operands stay frozen through the gap; the next word loads on the way out.
        if (gap_q == GapLast) begin
          state_d = StSend;
          gap_d   = '0;
          seq_adv = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef ADDER_STIM_LFSR_EN
  // Taps for x^42 + x^41 + x^20 + x^19 + 1; maximal-length only at the default 2N = 42.
  localparam logic [W-1:0] LfsrTaps = W'(64'h0000_0300_000C_0000);

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur);
    lfsr_step = {cur[W-2:0], ^(cur & LfsrTaps)};
  endfunction

  logic [W-1:0] lfsr_q;

  assign first_word = lfsr_step(Ones);
  assign next_word  = lfsr_step(lfsr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= Ones;
    end else if (seq_start) begin
      lfsr_q <= first_word;
    end else if (seq_adv) begin
      lfsr_q <= next_word;
    end
  end
`else
  localparam int unsigned KW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [KW-1:0] KLast = KW'(STEPS - 1);

  function automatic logic [W-1:0] walk_word(input logic [KW-1:0] k);
    logic [W-1:0] mask;
    mask = Ones << (SH * 32'(k));
    if (k == '0) begin
      walk_word = '0;
    end else if (k[0]) begin
      walk_word = mask;
    end else begin
      walk_word = ~mask;
    end
  endfunction

  // k_q is the pattern index of the word currently on the operand outputs.
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_inc;

  assign k_inc      = (k_q == KLast) ? '0 : k_q + KW'(1);
  assign first_word = walk_word(KW'(1));
  assign next_word  = walk_word(k_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
    end else if (seq_start) begin
      k_q <= KW'(1);
    end else if (seq_adv) begin
      k_q <= k_inc;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      flit_q  <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      if (seq_start) begin
        word_q <= first_word;
      end else if (seq_adv) begin
        word_q <= next_word;
      end
    end
  end

  assign bus.out_valid = (state_q == StSend);
  assign bus.busy      = (state_q == StSend) || (state_q == StGap);
  assign bus.done      = (state_q == StDone);
  assign bus.input1    = word_q[N-1:0];
  assign bus.input2    = word_q[W-1:N];
  assign bus.flit_cnt  = flit_q;
  assign bus.pkt_cnt   = pkt_q;

endmodule

// File: tb/tb_adder_flit_stim_gen.sv
// Bench for adder_flit_stim_gen: directed runs on a default instance and a
// back-to-back (GAP=0, PAYLOAD=1, NUM_PKTS=3) instance, with a per-cycle stream model.
module tb_adder_flit_stim_gen;
  localparam int unsigned N       = 21;
  localparam int unsigned W       = 2 * N;
  localparam int unsigned PAYLOAD = 20;
  localparam int unsigned STEPS   = 7;
  localparam int unsigned SH      = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_flit_if #(.N(N)) if_a ();
  adder_flit_if #(.N(N)) if_b ();

  adder_flit_stim_gen #(.N(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  adder_flit_stim_gen #(.N(N), .PAYLOAD(1), .GAP(0), .NUM_PKTS(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word for the j-th accepted flit of a run (j from 0): pattern index k = (j+1) mod STEPS.
  function automatic logic [W-1:0] exp_word(input int unsigned j);
    int unsigned k;
    logic [W-1:0] m;
    k = (j + 1) % STEPS;
    m = {W{1'b1}} << (SH * k);
    if (k == 0) return '0;
    return (k % 2 == 1) ? m : ~m;
  endfunction

  // Stream model for instance A: each presented flit must be the next one in the run.
  int unsigned  m_idx = 0;
  logic [W-1:0] last_word = '0;
  logic         prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_idx     = 0;
      last_word = '0;
      prev_busy = 1'b0;
    end else begin
      if (if_a.busy && !prev_busy) m_idx = 0;
      if (if_a.out_valid) begin
        check("model_word", 64'({if_a.input2, if_a.input1}), 64'(exp_word(m_idx)));
        check("model_flit_cnt", 64'(if_a.flit_cnt), 64'(m_idx % PAYLOAD));
        check("model_pkt_cnt", 64'(if_a.pkt_cnt), 64'(m_idx / PAYLOAD));
        if (if_a.out_ready) begin
          last_word = exp_word(m_idx);
          m_idx++;
        end
      end else if (if_a.busy) begin
        check("gap_hold_word", 64'({if_a.input2, if_a.input1}), 64'(last_word));
        check("gap_flit_cnt", 64'(if_a.flit_cnt), 64'd0);
      end
      prev_busy = if_a.busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full default run with out_ready=1; poke=1 pulses start while busy and in DONE.
  task automatic run_full(input bit poke);
    int done_cyc = 0;
    int done_n   = 0;
    int valid_n  = 0;
    bit exp_v;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      exp_v = (c <= 263) && (((c - 1) % 27) < 20);
      check("frame_valid", 64'(if_a.out_valid), 64'(exp_v));
      if (if_a.out_valid) valid_n++;
      if (if_a.done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (!poke && (c == 1 || c == 8)) begin
        check("flit1_input1", 64'(if_a.input1), 64'h1F_FFC0);
        check("flit1_input2", 64'(if_a.input2), 64'h1F_FFFF);
      end
      if (!poke && c == 2) begin
        check("flit2_input1", 64'(if_a.input1), 64'h00_0FFF);
        check("flit2_input2", 64'(if_a.input2), 64'h0);
      end
      if (!poke && c == 7) check("flit7_word", 64'({if_a.input2, if_a.input1}), 64'h0);
      tick();
      if_a.start = poke && (c == 22 || c == 40 || c == 100 || c == 263);
    end
    if_a.start = 1'b0;
    check("done_cycle", 64'(done_cyc), 64'd264);
    check("done_pulses", 64'(done_n), 64'd1);
    check("valid_cycles", 64'(valid_n), 64'd200);
    check("final_pkt_cnt", 64'(if_a.pkt_cnt), 64'd10);
    check("final_busy", 64'(if_a.busy), 64'd0);
  endtask

  initial begin
    logic [15:0]  f0;
    logic [W-1:0] w0;
    bit           found;
    int           done_cyc;

    rst          = 1'b1;
    if_a.start   = 1'b0;
    if_a.out_ready = 1'b1;
    if_b.start   = 1'b0;
    if_b.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_busy", 64'(if_a.busy), 64'd0);
    check("rst_done", 64'(if_a.done), 64'd0);
    check("rst_input1", 64'(if_a.input1), 64'd0);
    check("rst_input2", 64'(if_a.input2), 64'd0);
    check("rst_flit_cnt", 64'(if_a.flit_cnt), 64'd0);
    check("rst_pkt_cnt", 64'(if_a.pkt_cnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    run_full(1'b0);
    tick();
    run_full(1'b1);
    tick();

    // Stall mid-packet, then reset during the gap after packet 4.
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    found = 1'b0;
    f0 = '0;
    w0 = '0;
    for (int c = 1; c <= 250 && !found; c++) begin
      @(negedge clk);
      if (c == 31) begin
        f0 = if_a.flit_cnt;
        w0 = {if_a.input2, if_a.input1};
        check("stall_flit_cnt", 64'(f0), 64'd3);
      end
      if (c > 31 && c <= 35) begin
        check("stall_flit_frozen", 64'(if_a.flit_cnt), 64'(f0));
        check("stall_word_stable", 64'({if_a.input2, if_a.input1}), 64'(w0));
        check("stall_valid_held", 64'(if_a.out_valid), 64'd1);
      end
      if (if_a.pkt_cnt == 16'd4 && if_a.busy && !if_a.out_valid) begin
        found = 1'b1;
      end else begin
        tick();
        if_a.out_ready = !(c >= 30 && c < 35);
      end
    end
    if_a.out_ready = 1'b1;
    check("reach_gap_pkt4", 64'(found), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("midrst_busy", 64'(if_a.busy), 64'd0);
    check("midrst_done", 64'(if_a.done), 64'd0);
    check("midrst_operands", 64'({if_a.input2, if_a.input1}), 64'd0);
    check("midrst_counters", 64'({if_a.pkt_cnt, if_a.flit_cnt}), 64'd0);
    tick();
    rst = 1'b0;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    @(negedge clk);
    check("restart_valid", 64'(if_a.out_valid), 64'd1);
    check("restart_input1", 64'(if_a.input1), 64'h1F_FFC0);
    check("restart_input2", 64'(if_a.input2), 64'h1F_FFFF);
    done_cyc = 0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      tick();
      @(negedge clk);
      if (if_a.done) done_cyc = c;
    end
    check("restart_done_seen", 64'(done_cyc != 0), 64'd1);
    check("restart_pkt_cnt", 64'(if_a.pkt_cnt), 64'd10);
    tick();

    // Back-to-back instance: three valid cycles, then done.
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("b2b_valid", 64'(if_b.out_valid), 64'(c <= 3));
      check("b2b_done", 64'(if_b.done), 64'(c == 4));
      if (c == 1) check("b2b_flit1", 64'({if_b.input2, if_b.input1}), 64'h3FF_FFFF_FFC0);
      if (c == 2) check("b2b_flit2", 64'({if_b.input2, if_b.input1}), 64'h000_0000_0FFF);
      if (c == 3) check("b2b_flit3", 64'({if_b.input2, if_b.input1}), 64'h3FF_FFFC_0000);
      if (c == 3) check("b2b_pkt_cnt_mid", 64'(if_b.pkt_cnt), 64'd2);
      tick();
    end
    check("b2b_pkt_cnt", 64'(if_b.pkt_cnt), 64'd3);
    check("b2b_flit_cnt", 64'(if_b.flit_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
